// File: rtl/perf_pkg.sv
// Shared types for the cache performance counters: controller states and
// read-select encodings.
package perf_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      FROZEN = 2'd2
   } perf_state_e;

   localparam logic [1:0] SEL_CYCLES   = 2'd0;
   localparam logic [1:0] SEL_ACCESSES = 2'd1;
   localparam logic [1:0] SEL_HITS     = 2'd2;
   localparam logic [1:0] SEL_STALLS   = 2'd3;

   localparam int NUM_CNT = 4;

endpackage

// File: rtl/perf_event_cntr.sv
// Hold-able event counter with a sticky overflow flag. With PERF_SATURATE_EN
// defined the count sticks at all-ones, otherwise it wraps to zero.
module perf_event_cntr #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc) begin
         if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
`ifdef PERF_SATURATE_EN
            cnt_d = CNT_MAX;
`else
            cnt_d = '0;
`endif
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt = cnt_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/cache_perf_counters.sv
// Cache event counters (cycles/accesses/hits/stalls) under a run/freeze/clear
// controller, with a registered read port. PERF_SATURATE_EN selects saturation.
//
// state  | meaning
// IDLE   | cleared or after reset, counters held
// COUNT  | counters advance on their events
// FROZEN | counting paused, values retained until start or clear
module cache_perf_counters
   import perf_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             freeze,
   input  logic             clear,
   input  logic             access_valid,
   input  logic             access_hit,
   input  logic             stall,
   input  logic [1:0]       rd_sel,
   output logic [CNT_W-1:0] rd_data,
   output logic             overflow,
   output logic             busy
);

   perf_state_e state_q, state_d;
   logic        cnt_en;

   logic [CNT_W-1:0]   cnt_val [NUM_CNT];
   logic [NUM_CNT-1:0] ovf_flag;
   logic [NUM_CNT-1:0] inc;

   logic [CNT_W-1:0] rd_data_q, rd_data_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // clear outranks start/freeze; in COUNT freeze outranks start
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start)  state_d = COUNT;
            COUNT:   if (freeze) state_d = FROZEN;
            FROZEN:  if (start)  state_d = COUNT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy   = (state_q == COUNT);
      cnt_en = (state_q == COUNT);
   end

   assign inc[SEL_CYCLES]   = cnt_en;
   assign inc[SEL_ACCESSES] = cnt_en & access_valid;
   assign inc[SEL_HITS]     = cnt_en & access_valid & access_hit;
   assign inc[SEL_STALLS]   = cnt_en & stall;

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cntr
      perf_event_cntr #(.CNT_W(CNT_W)) u_cntr (
         .clk   (clk),
         .reset (reset),
         .clr   (clear),
         .inc   (inc[g]),
         .cnt   (cnt_val[g]),
         .ovf   (ovf_flag[g])
      );
   end

   // read port samples the pre-increment value of the selected counter
   always_comb begin
      rd_data_d = cnt_val[0];
      case (rd_sel)
         SEL_CYCLES:   rd_data_d = cnt_val[0];
         SEL_ACCESSES: rd_data_d = cnt_val[1];
         SEL_HITS:     rd_data_d = cnt_val[2];
         SEL_STALLS:   rd_data_d = cnt_val[3];
         default:      rd_data_d = cnt_val[0];
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_data_q <= '0;
      else       rd_data_q <= rd_data_d;
   end

   assign rd_data  = rd_data_q;
   assign overflow = |ovf_flag;

endmodule

// File: tb/tb_cache_perf_counters.sv
// Bench for cache_perf_counters: a 32-bit instance checked against a small
// reference model and a 4-bit instance for the wrap/saturate boundary.
module tb_cache_perf_counters;

   localparam int W  = 32;
   localparam int W4 = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic         start, freeze, clear, access_valid, access_hit, stall;
   logic [1:0]   rd_sel;
   logic [W-1:0] rd_data;
   logic         overflow, busy;

   logic          start4, freeze4, clear4, zero4;
   logic [1:0]    rd_sel4;
   logic [W4-1:0] rd_data4;
   logic          overflow4, busy4;

   cache_perf_counters #(.CNT_W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .freeze(freeze), .clear(clear),
      .access_valid(access_valid), .access_hit(access_hit), .stall(stall),
      .rd_sel(rd_sel), .rd_data(rd_data), .overflow(overflow), .busy(busy)
   );

   cache_perf_counters #(.CNT_W(W4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .freeze(freeze4), .clear(clear4),
      .access_valid(zero4), .access_hit(zero4), .stall(zero4),
      .rd_sel(rd_sel4), .rd_data(rd_data4), .overflow(overflow4), .busy(busy4)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0]  exp_q  [$];
   logic [W4-1:0] exp4_q [$];

   // reference model of the 32-bit instance: 0 idle, 1 count, 2 frozen
   logic [W-1:0] m_cnt [4];
   int           m_state;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
      m_state = 0;
   endtask

   // one clock of stimulus; queues the rd_data expected after this edge
   task automatic step(input logic s, input logic f, input logic c,
                       input logic av, input logic ah, input logic st);
      start = s; freeze = f; clear = c;
      access_valid = av; access_hit = ah; stall = st;
      exp_q.delete();
      exp_q.push_back(m_cnt[rd_sel]);
      @(posedge clk);
      if (c) begin
         model_reset();
      end else begin
         if (m_state == 1) begin
            m_cnt[0] = m_cnt[0] + 1;
            if (av)       m_cnt[1] = m_cnt[1] + 1;
            if (av && ah) m_cnt[2] = m_cnt[2] + 1;
            if (st)       m_cnt[3] = m_cnt[3] + 1;
         end
         case (m_state)
            0: if (s) m_state = 1;
            1: if (f) m_state = 2;
            2: if (s) m_state = 1;
            default: m_state = 0;
         endcase
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 0; freeze = 0; clear = 0; access_valid = 0; access_hit = 0; stall = 0;
      rd_sel = 2'd0;
      start4 = 0; freeze4 = 0; clear4 = 0; zero4 = 0; rd_sel4 = 2'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      n_checks++; if (rd_data4 !== '0) begin n_fail++; $display("FAIL reset_rd_data4: got %0d expected 0", rd_data4); end
   endtask

   task automatic test_count();
      logic [W-1:0] exp;
      rd_sel = 2'd0;
      step(1, 0, 0, 0, 0, 0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL count_busy_start: got %b expected 1", busy); end
      for (int i = 0; i < 9; i++) step(0, 0, 0, 1, (i % 2 == 0), 0);
      step(0, 1, 0, 1, 0, 0);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL count_busy_freeze: got %b expected 0", busy); end
      for (int sel = 0; sel < 3; sel++) begin
         rd_sel = 2'(sel);
         step(0, 0, 0, 0, 0, 0);
         exp = exp_q.pop_front();
         n_checks++;
         if (rd_data !== exp) begin n_fail++; $display("FAIL count_read sel=%0d: got %0d expected %0d", sel, rd_data, exp); end
      end
   endtask

   task automatic test_freeze_stall();
      logic [W-1:0] exp;
      rd_sel = 2'd0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 0, 1);
         exp = exp_q.pop_front();
         n_checks++;
         if (rd_data !== exp) begin n_fail++; $display("FAIL frozen_cycles i=%0d: got %0d expected %0d", i, rd_data, exp); end
      end
      step(1, 0, 0, 0, 0, 1);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL resume_busy: got %b expected 1", busy); end
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 1);
      rd_sel = 2'd3;
      step(0, 0, 0, 0, 0, 0);
      exp = exp_q.pop_front();
      n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL stalls_read: got %0d expected %0d", rd_data, exp); end
      rd_sel = 2'd0;
      step(0, 0, 0, 0, 0, 0);
      exp = exp_q.pop_front();
      n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL cycles_after_resume: got %0d expected %0d", rd_data, exp); end
   endtask

   task automatic test_clear();
      logic [W-1:0] exp;
      rd_sel = 2'd1;
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 1);
      step(1, 0, 1, 1, 1, 1);
      exp = exp_q.pop_front();
      n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL clear_edge_read: got %0d expected %0d", rd_data, exp); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %b expected 0", busy); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_overflow: got %b expected 0", overflow); end
      for (int sel = 0; sel < 4; sel++) begin
         rd_sel = 2'(sel);
         step(0, 0, 0, 0, 0, 0);
         exp = exp_q.pop_front();
         n_checks++;
         if (rd_data !== exp) begin n_fail++; $display("FAIL clear_read sel=%0d: got %0d expected %0d", sel, rd_data, exp); end
      end
   endtask

   task automatic test_start_freeze();
      logic [W-1:0] exp;
      rd_sel = 2'd0;
      step(1, 1, 0, 0, 0, 0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL idle_start_freeze_busy: got %b expected 1", busy); end
      step(1, 1, 0, 0, 0, 0);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL count_start_freeze_busy: got %b expected 0", busy); end
      step(0, 0, 0, 0, 0, 0);
      exp = exp_q.pop_front();
      n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL start_freeze_cycles: got %0d expected %0d", rd_data, exp); end
   endtask

   task automatic test_overflow();
      logic [W4-1:0] exp;
      rd_sel4 = 2'd0;
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL ovf_busy_start: got %b expected 1", busy4); end
      repeat (15) @(posedge clk);
      #1;
      n_checks++; if (overflow4 !== 1'b0) begin n_fail++; $display("FAIL ovf_at_max_early: got %b expected 0", overflow4); end
      exp4_q.push_back(4'd15);
      freeze4 = 1'b1;
      @(posedge clk); #1;
      freeze4 = 1'b0;
      exp = exp4_q.pop_front();
      n_checks++; if (rd_data4 !== exp) begin n_fail++; $display("FAIL ovf_pre_wrap_read: got %0d expected %0d", rd_data4, exp); end
      n_checks++; if (overflow4 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag_set: got %b expected 1", overflow4); end
      n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_freeze: got %b expected 0", busy4); end
`ifdef PERF_SATURATE_EN
      exp4_q.push_back(4'd15);
`else
      exp4_q.push_back(4'd0);
`endif
      @(posedge clk); #1;
      exp = exp4_q.pop_front();
      n_checks++; if (rd_data4 !== exp) begin n_fail++; $display("FAIL ovf_cycles_after: got %0d expected %0d", rd_data4, exp); end
      rd_sel4 = 2'd1;
      exp4_q.push_back(4'd0);
      @(posedge clk); #1;
      exp = exp4_q.pop_front();
      n_checks++; if (rd_data4 !== exp) begin n_fail++; $display("FAIL ovf_accesses: got %0d expected %0d", rd_data4, exp); end
      n_checks++; if (overflow4 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow4); end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] exp;
      rd_sel = 2'd0;
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      exp = exp_q.pop_front();
      n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL pre_reset_read: got %0d expected %0d", rd_data, exp); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b expected 1", busy); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL async_rd_data: got %0d expected 0", rd_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b expected 0", busy); end
      n_checks++; if (overflow4 !== 1'b0) begin n_fail++; $display("FAIL async_overflow4: got %b expected 0", overflow4); end
      #1 reset = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, 1, 1);
         exp = exp_q.pop_front();
         n_checks++;
         if (rd_data !== exp || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle i=%0d: got %0d busy %b expected %0d busy 0", i, rd_data, busy, exp);
         end
      end
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      rd_sel = 2'd1;
      step(0, 0, 0, 0, 0, 0);
      exp = exp_q.pop_front();
      n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL post_reset_accesses: got %0d expected %0d", rd_data, exp); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 1", busy); end
   endtask

   initial begin
      test_reset();
      test_count();
      test_freeze_stall();
      test_clear();
      test_start_freeze();
      test_overflow();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
